// File: rtl/omr_pkg.sv
// rtl/omr_pkg.sv - shared defaults and per-question grade type for the OMR grader
package omr_pkg;

  localparam int NUM_Q_DEF = 10;
  localparam int OPT_W_DEF = 4;

  typedef enum logic [1:0] {
    Q_BLANK   = 2'd0,
    Q_CORRECT = 2'd1,
    Q_WRONG   = 2'd2,
    Q_VOID    = 2'd3
  } q_grade_t;

endpackage

// File: rtl/omr_question_grader.sv
// rtl/omr_question_grader.sv - classifies one question's mark against its key
module omr_question_grader
  import omr_pkg::*;
#(
  parameter int OPT_W = OPT_W_DEF
) (
  input  logic [OPT_W-1:0] key_i,
  input  logic [OPT_W-1:0] mark_i,
  output q_grade_t         grade_o
);

  logic key_onehot;

  // A key that is not exactly one-hot voids the question regardless of the mark.
  assign key_onehot = (key_i != '0) && ((key_i & (key_i - OPT_W'(1))) == '0);

  always_comb begin
    grade_o = Q_WRONG;
    if (!key_onehot) begin
      grade_o = Q_VOID;
    end else if (mark_i == '0) begin
      grade_o = Q_BLANK;
    end else if (mark_i == key_i) begin
      grade_o = Q_CORRECT;
    end
  end

endmodule

// File: rtl/omr_grader.sv
// rtl/omr_grader.sv - grades a full sheet with negative marking, registered score outputs
module omr_grader
  import omr_pkg::*;
#(
  parameter int NUM_Q = NUM_Q_DEF,
  parameter int OPT_W = OPT_W_DEF,
  parameter int SCW   = $clog2(NUM_Q + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_Q*OPT_W-1:0] correct_answers,
  input  logic [NUM_Q*OPT_W-1:0] student_answers,
  output logic [SCW-1:0]         score,
  output logic [SCW-1:0]         score_neg
);

  localparam int CW = $clog2(NUM_Q + 1);

  q_grade_t grade [NUM_Q];

  for (genvar q = 0; q < NUM_Q; q++) begin : g_question
    omr_question_grader #(.OPT_W(OPT_W)) u_grader (
      .key_i   (correct_answers[q*OPT_W +: OPT_W]),
      .mark_i  (student_answers[q*OPT_W +: OPT_W]),
      .grade_o (grade[q])
    );
  end

  logic [CW-1:0]  n_c;
  logic [CW-1:0]  n_w;
  logic [CW:0]    net;
  logic [CW-1:0]  neg_mag;
  logic [SCW-1:0] score_d;
  logic [SCW-1:0] score_neg_d;
  logic [SCW-1:0] score_q;
  logic [SCW-1:0] score_neg_q;

  always_comb begin
    n_c = '0;
    n_w = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      n_c = n_c + CW'(grade[q] == Q_CORRECT);
      n_w = n_w + CW'(grade[q] == Q_WRONG);
    end
  end

  // One extra bit makes the difference signed; the magnitude is taken directly
  // from the counts so it never needs the sign bit.
  assign net     = {1'b0, n_c} - {1'b0, n_w};
  assign neg_mag = n_w - n_c;

  always_comb begin
    score_d     = '0;
    score_neg_d = '0;
    if (net[CW]) begin
      score_neg_d = SCW'(neg_mag);
    end else begin
      score_d = SCW'(net[CW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q     <= '0;
      score_neg_q <= '0;
    end else begin
      score_q     <= score_d;
      score_neg_q <= score_neg_d;
    end
  end

  assign score     = score_q;
  assign score_neg = score_neg_q;

endmodule

// File: tb/tb_omr_grader.sv
// tb/tb_omr_grader.sv - randomized and directed self-checking bench for omr_grader
module tb_omr_grader;

  localparam int NQ = 10;
  localparam int OW = 4;
  localparam int SW = 4;
  localparam logic [NQ*OW-1:0] KEY = 40'h1224441888;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NQ*OW-1:0] key = '0;
  logic [NQ*OW-1:0] mark = '0;
  logic [SW-1:0] score;
  logic [SW-1:0] score_neg;

  int checks = 0;
  int failures = 0;

  logic [SW-1:0] exp_s = '0;
  logic [SW-1:0] exp_n = '0;
  logic          valid = 1'b0;

  omr_grader #(.NUM_Q(NQ), .OPT_W(OW), .SCW(SW)) dut (
    .clk             (clk),
    .reset           (reset),
    .correct_answers (key),
    .student_answers (mark),
    .score           (score),
    .score_neg       (score_neg)
  );

  always #5 clk = ~clk;

  function automatic int model_net(input logic [NQ*OW-1:0] k, input logic [NQ*OW-1:0] m);
    int net;
    logic [OW-1:0] kn;
    logic [OW-1:0] mn;
    net = 0;
    for (int q = 0; q < NQ; q++) begin
      kn = k[q*OW +: OW];
      mn = m[q*OW +: OW];
      if ($countones(kn) != 1) continue;
      if (mn == '0) continue;
      if (mn == kn) net = net + 1;
      else net = net - 1;
    end
    return net;
  endfunction

  function automatic int pos_part(input int net);
    return (net > 0) ? net : 0;
  endfunction

  function automatic int neg_part(input int net);
    return (net < 0) ? -net : 0;
  endfunction

  // Reference expectation for whatever the DUT captures at this edge.
  always @(posedge clk) begin
    valid <= 1'b1;
    if (reset) begin
      exp_s <= '0;
      exp_n <= '0;
    end else begin
      exp_s <= SW'(pos_part(model_net(key, mark)));
      exp_n <= SW'(neg_part(model_net(key, mark)));
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (score !== exp_s || score_neg !== exp_n) begin
        failures++;
        $display("FAIL model_cmp t=%0t score=%0d score_neg=%0d required %0d/%0d",
                 $time, score, score_neg, exp_s, exp_n);
      end
    end
  end

  task automatic sheet(input string name, input logic [NQ*OW-1:0] k,
                       input logic [NQ*OW-1:0] m, input int es, input int en);
    int net;
    @(negedge clk);
    reset = 1'b0;
    key   = k;
    mark  = m;
    net = model_net(k, m);
    checks++;
    if (pos_part(net) != es || neg_part(net) != en) begin
      failures++;
      $display("FAIL model_%s model=%0d/%0d required %0d/%0d", name, pos_part(net), neg_part(net), es, en);
    end
    @(posedge clk);
    #1;
    checks++;
    if (score !== SW'(es) || score_neg !== SW'(en)) begin
      failures++;
      $display("FAIL dut_%s score=%0d score_neg=%0d required %0d/%0d", name, score, score_neg, es, en);
    end
  endtask

  function automatic logic [NQ*OW-1:0] rand_key();
    logic [NQ*OW-1:0] k;
    logic [OW-1:0] nib;
    for (int q = 0; q < NQ; q++) begin
      if ($urandom_range(0, 9) == 0) nib = OW'($urandom_range(0, 15));
      else nib = OW'(1 << $urandom_range(0, OW-1));
      k[q*OW +: OW] = nib;
    end
    return k;
  endfunction

  function automatic logic [NQ*OW-1:0] rand_mark(input logic [NQ*OW-1:0] k);
    logic [NQ*OW-1:0] m;
    logic [OW-1:0] nib;
    int r;
    for (int q = 0; q < NQ; q++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) nib = '0;
      else if (r < 5) nib = k[q*OW +: OW];
      else if (r < 8) nib = OW'(1 << $urandom_range(0, OW-1));
      else nib = OW'($urandom_range(0, 15));
      m[q*OW +: OW] = nib;
    end
    return m;
  endfunction

  initial begin
    // Reset held for two edges with a perfect sheet applied: reset must win.
    key  = KEY;
    mark = KEY;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (score !== '0 || score_neg !== '0) begin
        failures++;
        $display("FAIL reset_%0d score=%0d score_neg=%0d required 0/0", i, score, score_neg);
      end
    end

    sheet("release_full", KEY, KEY, 10, 0);
    sheet("six_four",     KEY, 40'h1214421281, 2, 0);
    sheet("one_nine",     KEY, 40'h8421524212, 0, 8);
    sheet("five_five",    KEY, 40'h8124821488, 0, 0);
    sheet("all_blank",    KEY, 40'h0000000000, 0, 0);
    sheet("void_q0",      40'h1224441880, 40'h1224441880, 9, 0);
    sheet("b2b_first",    KEY, KEY, 10, 0);
    sheet("b2b_second",   KEY, 40'h1228411888, 6, 0);
    sheet("all_wrong",    KEY, 40'h4441118222, 0, 10);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 29) == 0);
      key   = rand_key();
      mark  = rand_mark(key);
    end

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
